rv_decode_exec: RTL and testbench

RV_DECODE_EXEC -- requirements
Module: rv_decode_exec

---
 rtl/rv_pkg.sv | 41 ++++
 rtl/rv_decode_exec_if.sv | 23 ++
 rtl/rv_regfile.sv | 36 +++
 rtl/rv_decode_exec.sv | 215 +++++++++++++++++++++
 tb/tb_rv_decode_exec.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared encodings, FSM state type and commit control payload for rv_decode_exec.
package rv_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned ILEN         = 32;
  localparam int unsigned REG_AW       = 5;

  // Major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LEDW   = 7'b0000111;

  // funct3 values
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_LEDW = 3'b000;

  // funct7 values
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Side effects of the latched instruction, applied when EXEC ends
  typedef struct packed {
    logic              wb_en;
    logic [REG_AW-1:0] rd;
    logic              led_en;
    logic              illegal;
  } commit_ctl_t;

endpackage

// File: rtl/rv_decode_exec_if.sv
// Fetch-side handshake: instruction offer in, ready and redirect back to fetch.
interface rv_decode_exec_if #(
  parameter int unsigned PC_W = 32
);

  logic            ir_valid;
  logic [31:0]     ir;
  logic [PC_W-1:0] ir_pc;
  logic            ir_ready;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output ir_valid, ir, ir_pc,
    input  ir_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  ir_valid, ir, ir_pc,
    output ir_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/rv_regfile.sv
// 32 x XLEN register file: two async read ports, one write port, x0 reads zero.
module rv_regfile
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic              clock_1hz,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [XLEN-1:0]   o_rdata1,
  output logic [XLEN-1:0]   o_rdata2
);

  localparam int unsigned NREGS = 32;

  logic [XLEN-1:0] r_mem [NREGS];

  // Storage with async clear; writes to x0 are dropped
  always_ff @(posedge clock_1hz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != REG_AW'(0))) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == REG_AW'(0)) ? '0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == REG_AW'(0)) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/rv_decode_exec.sv
// Decode/execute stage: accepts one instruction in IDLE, commits it at the end of EXEC.
module rv_decode_exec
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned PC_W = 32
) (
  input  logic             clock_1hz,
  input  logic             reset_n,
  rv_decode_exec_if.slave  bus,
  output logic [7:0]       led_out,
  output logic             trap,
  output logic             retired
);

  state_e            r_state;
  state_e            w_next_state;
  logic              w_accept;
  logic              w_commit;

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [XLEN-1:0]   w_rdata1;
  logic [XLEN-1:0]   w_rdata2;

  logic [XLEN-1:0]   w_imm_i;
  logic [XLEN-1:0]   w_imm_u;
  logic [XLEN-1:0]   w_imm_b;
  logic [XLEN-1:0]   w_imm_j;
  logic [XLEN-1:0]   w_pc_byte;
  logic [XLEN-1:0]   w_link;
  logic [PC_W-1:0]   w_br_target;
  logic [PC_W-1:0]   w_jal_target;

  commit_ctl_t       w_ctl;
  logic [XLEN-1:0]   w_wb_data;
  logic [7:0]        w_led_val;
  logic              w_take;
  logic [PC_W-1:0]   w_target;

  commit_ctl_t       r_ctl;
  logic [XLEN-1:0]   r_wb_data;
  logic [7:0]        r_led_val;

  assign w_opcode = bus.ir[6:0];
  assign w_funct3 = bus.ir[14:12];
  assign w_funct7 = bus.ir[31:25];
  assign w_rs1    = bus.ir[19:15];
  assign w_rs2    = bus.ir[24:20];

  // Immediates, sign-extended to XLEN
  assign w_imm_i = XLEN'($signed(bus.ir[31:20]));
  assign w_imm_u = XLEN'($signed({bus.ir[31:12], 12'b0}));
  assign w_imm_b = XLEN'($signed({bus.ir[31], bus.ir[7], bus.ir[30:25], bus.ir[11:8], 1'b0}));
  assign w_imm_j = XLEN'($signed({bus.ir[31], bus.ir[19:12], bus.ir[20], bus.ir[30:21], 1'b0}));

  // ir_pc is a word index; byte addresses are formed by scaling by 4
  assign w_pc_byte    = XLEN'(bus.ir_pc) << 2;
  assign w_link       = (XLEN'(bus.ir_pc) + XLEN'(1)) << 2;
  assign w_br_target  = bus.ir_pc + PC_W'($signed(w_imm_b) >>> 2);
  assign w_jal_target = bus.ir_pc + PC_W'($signed(w_imm_j) >>> 2);

  rv_regfile #(
    .XLEN (XLEN)
  ) u_regfile (
    .clock_1hz (clock_1hz),
    .reset_n   (reset_n),
    .i_we      (w_commit && r_ctl.wb_en),
    .i_waddr   (r_ctl.rd),
    .i_wdata   (r_wb_data),
    .i_raddr1  (w_rs1),
    .i_raddr2  (w_rs2),
    .o_rdata1  (w_rdata1),
    .o_rdata2  (w_rdata2)
  );

  // Decode and evaluate the offered instruction; only used when it is accepted
  always_comb begin
    w_ctl       = '0;
    w_ctl.rd    = bus.ir[11:7];
    w_wb_data   = '0;
    w_led_val   = '0;
    w_take      = 1'b0;
    w_target    = '0;
    if (bus.ir != 32'd0) begin
      case (w_opcode)
        OP_LUI: begin
          w_ctl.wb_en = 1'b1;
          w_wb_data   = w_imm_u;
        end
        OP_AUIPC: begin
          w_ctl.wb_en = 1'b1;
          w_wb_data   = w_pc_byte + w_imm_u;
        end
        OP_IMM: begin
          if (w_funct3 == F3_ADD) begin
            w_ctl.wb_en = 1'b1;
            w_wb_data   = w_rdata1 + w_imm_i;
          end else begin
            w_ctl.illegal = 1'b1;
          end
        end
        OP_REG: begin
          if ((w_funct3 == F3_ADD) && (w_funct7 == F7_ADD)) begin
            w_ctl.wb_en = 1'b1;
            w_wb_data   = w_rdata1 + w_rdata2;
          end else if ((w_funct3 == F3_ADD) && (w_funct7 == F7_SUB)) begin
            w_ctl.wb_en = 1'b1;
            w_wb_data   = w_rdata1 - w_rdata2;
          end else begin
            w_ctl.illegal = 1'b1;
          end
        end
        OP_BRANCH: begin
          w_target = w_br_target;
          if (w_funct3 == F3_BEQ) begin
            w_take = (w_rdata1 == w_rdata2);
          end else if (w_funct3 == F3_BNE) begin
            w_take = (w_rdata1 != w_rdata2);
          end else begin
            w_ctl.illegal = 1'b1;
          end
        end
        OP_JAL: begin
          w_ctl.wb_en = 1'b1;
          w_wb_data   = w_link;
          w_take      = 1'b1;
          w_target    = w_jal_target;
        end
        OP_LEDW: begin
          if (w_funct3 == F3_LEDW) begin
            w_ctl.led_en = 1'b1;
            w_led_val    = w_rdata1[7:0];
          end else begin
            w_ctl.illegal = 1'b1;
          end
        end
        default: begin
          w_ctl.illegal = 1'b1;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clock_1hz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and stage strobes
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.ir_valid && bus.ir_ready) begin
          w_accept     = 1'b1;
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_commit     = 1'b1;
        w_next_state = r_ctl.illegal ? ST_HALT : ST_IDLE;
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Latched instruction effects and registered outputs
  always_ff @(posedge clock_1hz or negedge reset_n) begin
    if (!reset_n) begin
      r_ctl              <= '0;
      r_wb_data          <= '0;
      r_led_val          <= '0;
      bus.ir_ready       <= 1'b1;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      led_out            <= '0;
      trap               <= 1'b0;
      retired            <= 1'b0;
    end else begin
      bus.ir_ready       <= (w_next_state == ST_IDLE);
      bus.redirect_valid <= w_accept && w_take;
      if (w_accept && w_take) begin
        bus.redirect_pc <= w_target;
      end
      if (w_accept) begin
        r_ctl     <= w_ctl;
        r_wb_data <= w_wb_data;
        r_led_val <= w_led_val;
      end
      retired <= w_commit && !r_ctl.illegal;
      if (w_commit && r_ctl.led_en) begin
        led_out <= r_led_val;
      end
      if (w_commit && r_ctl.illegal) begin
        trap <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_decode_exec.sv
// Scoreboard bench for rv_decode_exec: driver queues expectations, monitor checks completions.
module tb_rv_decode_exec;

  logic clk;
  logic reset_n;
  logic [7:0] led_out;
  logic trap;
  logic retired;

  rv_decode_exec_if #(.PC_W(32)) bus ();

  rv_decode_exec #(
    .XLEN (64),
    .PC_W (32)
  ) dut (
    .clock_1hz (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .led_out   (led_out),
    .trap      (trap),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic [7:0]  led;
    logic        trp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_ret = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd, input int op);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
    return {20'(imm20), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [12:0] b;
    b = 13'(imm);
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'(f3), b[4:1], b[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] j;
    j = 21'(imm);
    return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'b1101111};
  endfunction

  localparam int LUI = 'h37, AUIPC = 'h17, IMM = 'h13, REG = 'h33, LEDW = 'h07;

  function automatic logic [31:0] ledw(input int rs1);
    return enc_i(0, rs1, 0, 0, LEDW);
  endfunction

  // Offer one instruction once ready is seen; optionally queue its expected completion
  task automatic issue(input logic [31:0] w, input int pc, input logic redir, input int rpc,
                       input logic [7:0] led, input logic trp, input bit push);
    int n;
    exp_t e;
    n = 0;
    while (!bus.ir_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ir_ready) begin
      chk("ready_timeout", 64'(bus.ir_ready), 64'(1));
      return;
    end
    bus.ir_valid = 1'b1;
    bus.ir       = w;
    bus.ir_pc    = 32'(pc);
    if (push) begin
      e.redir = redir;
      e.rpc   = 32'(rpc);
      e.led   = led;
      e.trp   = trp;
      q.push_back(e);
    end
    @(negedge clk);
    bus.ir_valid = 1'b0;
  endtask

  task automatic go(input logic [31:0] w, input int pc, input logic [7:0] led);
    issue(w, pc, 1'b0, 0, led, 1'b0, 1'b1);
  endtask

  task automatic br(input logic [31:0] w, input int pc, input logic redir, input int rpc, input logic [7:0] led);
    issue(w, pc, redir, rpc, led, 1'b0, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'(0));
  endtask

  task automatic do_reset();
    bus.ir_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_led_now", 64'(led_out), 64'(0));
    chk("rst_trap_now", 64'(trap), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_ready", 64'(bus.ir_ready), 64'(1));
    chk("rst_redir", 64'(bus.redirect_valid), 64'(0));
    chk("rst_redir_pc", 64'(bus.redirect_pc), 64'(0));
    chk("rst_retired", 64'(retired), 64'(0));
  endtask

  task automatic check_halt(input string name);
    bus.ir_valid = 1'b1;
    bus.ir       = enc_i(1, 0, 0, 1, IMM);
    bus.ir_pc    = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk(name, 64'(bus.ir_ready), 64'(0));
    end
    bus.ir_valid = 1'b0;
    chk("halt_trap", 64'(trap), 64'(1));
  endtask

  // Monitor: capture redirect pulses, compare at each completion (retire or trap rise)
  initial begin : monitor
    logic        cap_redir;
    logic [31:0] cap_pc;
    logic        trap_seen;
    exp_t        e;
    cap_redir = 1'b0;
    cap_pc    = '0;
    trap_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cap_redir = 1'b0;
        trap_seen = 1'b0;
      end else begin
        if (bus.redirect_valid) begin
          if (cap_redir) chk("redir_double", 64'(1), 64'(0));
          cap_redir = 1'b1;
          cap_pc    = bus.redirect_pc;
        end
        if (retired) n_ret++;
        if (retired || (trap && !trap_seen)) begin
          if (q.size() == 0) begin
            chk("unexpected_completion", 64'(1), 64'(0));
          end else begin
            e = q.pop_front();
            chk("redirect", 64'(cap_redir), 64'(e.redir));
            if (e.redir) chk("redirect_pc", 64'(cap_pc), 64'(e.rpc));
            chk("led_out", 64'(led_out), 64'(e.led));
            chk("trap", 64'(trap), 64'(e.trp));
            chk("retired_vs_trap", 64'(retired), 64'(!e.trp));
          end
          cap_redir = 1'b0;
        end
        trap_seen = trap;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nr;
    reset_n      = 1'b0;
    bus.ir_valid = 1'b0;
    bus.ir       = '0;
    bus.ir_pc    = '0;
    do_reset();
    chk("reset_led", 64'(led_out), 64'(0));
    chk("reset_trap", 64'(trap), 64'(0));

    // ADDI / LEDW
    go(32'h00500093, 0, 8'h00);
    go(32'h00008007, 1, 8'h05);
    // LUI x2 and an identical x4; BEQ proves equality
    go(32'h12345137, 2, 8'h05);
    go(enc_u('h12345, 4, LUI), 3, 8'h05);
    br(enc_b(8, 4, 2, 0), 10, 1'b1, 12, 8'h05);
    // x3 = -1 + 1 wraps to 0
    go(enc_i(-1, 0, 0, 3, IMM), 11, 8'h05);
    go(enc_i(1, 3, 0, 3, IMM), 12, 8'h05);
    br(enc_b(8, 0, 3, 0), 20, 1'b1, 22, 8'h05);
    br(enc_b(8, 0, 3, 1), 21, 1'b0, 0, 8'h05);
    // BEQ x0,x0,+8 taken; BNE same operands not taken
    br(32'h00000463, 10, 1'b1, 12, 8'h05);
    br(32'h00001463, 10, 1'b0, 0, 8'h05);
    go(ledw(3), 13, 8'h00);
    // Backward branch from pc 0 wraps the word index
    br(enc_b(-4, 0, 0, 0), 0, 1'b1, -1, 8'h00);
    // AUIPC at pc 3 -> 12
    go(enc_u(0, 10, AUIPC), 3, 8'h00);
    go(ledw(10), 4, 8'h0C);
    // JAL x5,+8 at pc 20: target 22, link 84
    br(enc_j(8, 5), 20, 1'b1, 22, 8'h0C);
    go(ledw(5), 23, 8'h54);
    // JAL x0,-8 at pc 5: target 3, link discarded
    br(enc_j(-8, 0), 5, 1'b1, 3, 8'h54);
    // SUB / ADD
    go(enc_i(3, 0, 0, 11, IMM), 6, 8'h54);
    go(enc_r('h20, 11, 0, 0, 12, REG), 7, 8'h54);
    go(ledw(12), 8, 8'hFD);
    go(enc_r(0, 11, 11, 0, 13, REG), 9, 8'hFD);
    go(ledw(13), 10, 8'h06);
    // NOP leaves LEDs alone
    go(32'h00000000, 11, 8'h06);
    // Writes to x0 are discarded
    go(enc_i(7, 0, 0, 0, IMM), 12, 8'h06);
    go(ledw(0), 13, 8'h00);
    // LUI sign extension: -4096 + 2047 + 2047 + 2 == 0
    go(enc_u('hFFFFF, 8, LUI), 14, 8'h00);
    go(enc_i(2047, 8, 0, 9, IMM), 15, 8'h00);
    go(enc_i(2047, 9, 0, 9, IMM), 16, 8'h00);
    go(enc_i(2, 9, 0, 9, IMM), 17, 8'h00);
    br(enc_b(4, 0, 9, 0), 30, 1'b1, 31, 8'h00);
    go(ledw(13), 31, 8'h06);
    // Wrong funct7 traps
    issue(enc_r('h01, 2, 1, 0, 3, REG), 40, 1'b0, 0, 8'h06, 1'b1, 1'b1);
    wait_drain();
    check_halt("halt_f7_ready");
    do_reset();
    // Wrong funct3 on OP-IMM traps
    issue(enc_i(0, 1, 1, 2, IMM), 0, 1'b0, 0, 8'h00, 1'b1, 1'b1);
    wait_drain();
    check_halt("halt_f3_ready");
    do_reset();
    // All-ones word traps
    issue(32'hFFFFFFFF, 0, 1'b0, 0, 8'h00, 1'b1, 1'b1);
    wait_drain();
    check_halt("halt_ones_ready");
    do_reset();
    chk("post_trap_reset_trap", 64'(trap), 64'(0));
    // Reset during EXEC of LEDW x1 abandons it
    go(32'h00500093, 0, 8'h00);
    wait_drain();
    nr = n_ret;
    issue(32'h00008007, 1, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abandon_led", 64'(led_out), 64'(0));
    chk("abandon_retired", 64'(n_ret), 64'(nr));
    chk("abandon_ready", 64'(bus.ir_ready), 64'(1));
    // Registers were cleared by reset
    go(32'h00008007, 2, 8'h00);
    wait_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
